// File: rtl/stage_sequencer_if.sv
// Stage-sequencer bus: run/halt control, decode class bits and the
// memory-ready handshake going in; stage enables, status and debug state
// coming out. clk and reset are kept outside as plain ports.
//
// Handshake: mem_ready is a level from data memory, meaningful only while the
// sequencer is in MEMORY or MEM_WAIT (mem_en=1). A cycle with mem_en=1 and
// mem_ready=1 completes the access on that rising edge. mem_ready is ignored
// in every other state.
interface stage_sequencer_if #(
   parameter int COUNT_W = 32
);
   // Requests and decode information into the sequencer
   logic               run;
   logic               halt_req;
   logic               mem_read;
   logic               mem_write;
   logic               branch;
   logic               uncond_branch;
   logic               mem_ready;

   // Stage enables, status and debug out of the sequencer
   logic               fetch_en;
   logic               decode_en;
   logic               exec_en;
   logic               mem_en;
   logic               wb_en;
   logic               pc_update;
   logic               busy;
   logic               halted;
   logic               error;
   logic [COUNT_W-1:0] instr_count;
   logic [3:0]         state;

   // Sequencer side
   modport master (
      input  run, halt_req, mem_read, mem_write, branch, uncond_branch,
             mem_ready,
      output fetch_en, decode_en, exec_en, mem_en, wb_en, pc_update,
             busy, halted, error, instr_count, state
   );

   // Datapath / control side
   modport slave (
      output run, halt_req, mem_read, mem_write, branch, uncond_branch,
             mem_ready,
      input  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_update,
             busy, halted, error, instr_count, state
   );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle LEGv8 stage sequencer. Walks each instruction through
// FETCH, DECODE, EXECUTE and, depending on the decoded class, MEMORY
// and/or WRITEBACK, with run/halt control, a memory timeout into a sticky
// ERROR state and a retired-instruction counter.
//
// Stage enables and status flags are registered from the next state so they
// line up with the registered state. pc_update is the exception: it marks
// the final cycle of an instruction, which in the memory phase depends on
// mem_ready in that same cycle, so it is decoded combinationally.
module stage_sequencer #(
   parameter int COUNT_W     = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input logic               clk,
   input logic               reset,
   stage_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_MEMORY    = 4'd4,
      S_MEM_WAIT  = 4'd5,
      S_WRITEBACK = 4'd6,
      S_HALTED    = 4'd7,
      S_ERROR     = 4'd8
   } state_t;

   // Wait counter only has to reach MEM_TIMEOUT-1
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t             state_q, state_d;
   logic               is_mem_q;
   logic               no_wb_q;
   logic               halt_pend_q;
   logic [WAIT_W-1:0]  wait_q;
   logic [COUNT_W-1:0] count_q;

   logic               fetch_en_q, decode_en_q, exec_en_q, mem_en_q, wb_en_q;
   logic               busy_q, halted_q, error_q;

   logic               instr_end;
   logic               timeout_hit;
   logic               in_mem;
   logic               in_busy;

   assign in_mem      = (state_q == S_MEMORY) || (state_q == S_MEM_WAIT);
   assign in_busy     = (state_q == S_FETCH)   || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE) || in_mem ||
                        (state_q == S_WRITEBACK);
   assign timeout_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

   // Next-state selection and end-of-instruction detection
   always_comb begin
      state_d   = state_q;
      instr_end = 1'b0;
      case (state_q)
         S_IDLE:      if (bus.run) state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE:    state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (is_mem_q)      state_d = S_MEMORY;
            else if (!no_wb_q) state_d = S_WRITEBACK;
            else               instr_end = 1'b1;
         end
         S_MEMORY, S_MEM_WAIT: begin
            if (bus.mem_ready) begin
               if (!no_wb_q) state_d = S_WRITEBACK;
               else          instr_end = 1'b1;
            end else if (timeout_hit) begin
               state_d = S_ERROR;
            end else begin
               state_d = S_MEM_WAIT;
            end
         end
         S_WRITEBACK: instr_end = 1'b1;
         S_HALTED:    if (bus.run) state_d = S_FETCH;
         S_ERROR:     state_d = S_ERROR;
         default:     state_d = S_IDLE;
      endcase
      // Instruction boundary: stop here if a halt is pending or requested now
      if (instr_end) begin
         state_d = (halt_pend_q || bus.halt_req) ? S_HALTED : S_FETCH;
      end
   end

   // State, class bits, halt flag, wait counter, retire counter and
   // registered stage outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         is_mem_q    <= 1'b0;
         no_wb_q     <= 1'b0;
         halt_pend_q <= 1'b0;
         wait_q      <= '0;
         count_q     <= '0;
         fetch_en_q  <= 1'b0;
         decode_en_q <= 1'b0;
         exec_en_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         wb_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == S_DECODE) begin
            is_mem_q <= bus.mem_read | bus.mem_write;
            no_wb_q  <= bus.mem_write | bus.branch | bus.uncond_branch;
         end

         // A halt request arriving together with run in HALTED is carried
         // into the instruction that run starts.
         if (state_d == S_HALTED) begin
            halt_pend_q <= 1'b0;
         end else if (bus.halt_req &&
                      (in_busy || (state_q == S_HALTED && bus.run))) begin
            halt_pend_q <= 1'b1;
         end

         if (state_q == S_EXECUTE) begin
            wait_q <= '0;
         end else if (in_mem && !bus.mem_ready && !timeout_hit) begin
            wait_q <= wait_q + WAIT_W'(1);
         end

         if (instr_end) begin
            count_q <= count_q + COUNT_W'(1);
         end

         fetch_en_q  <= (state_d == S_FETCH);
         decode_en_q <= (state_d == S_DECODE);
         exec_en_q   <= (state_d == S_EXECUTE);
         mem_en_q    <= (state_d == S_MEMORY) || (state_d == S_MEM_WAIT);
         wb_en_q     <= (state_d == S_WRITEBACK);
         busy_q      <= (state_d == S_FETCH)   || (state_d == S_DECODE)   ||
                        (state_d == S_EXECUTE) || (state_d == S_MEMORY)   ||
                        (state_d == S_MEM_WAIT)|| (state_d == S_WRITEBACK);
         halted_q    <= (state_d == S_HALTED);
         error_q     <= (state_d == S_ERROR);
      end
   end

   // A reset in the final cycle abandons the instruction, so no PC load
   assign bus.pc_update   = instr_end & ~reset;
   assign bus.fetch_en    = fetch_en_q;
   assign bus.decode_en   = decode_en_q;
   assign bus.exec_en     = exec_en_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.wb_en       = wb_en_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.error       = error_q;
   assign bus.instr_count = count_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer. The reference model expands each instruction
// into its expected list of stage states from its class and memory delay,
// and keeps its own retired-instruction count.
module tb_stage_sequencer;
   localparam int CW = 4;
   localparam int MT = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_bad    = 0;
   int   mdl_count = 0;

   stage_sequencer_if #(.COUNT_W(CW)) bus();

   stage_sequencer #(.COUNT_W(CW), .MEM_TIMEOUT(MT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {fetch, decode, exec, mem, wb, busy, halted, error} expected per state
   function automatic logic [7:0] exp_outs(input int st);
      logic [7:0] v;
      v[7] = (st == 1);
      v[6] = (st == 2);
      v[5] = (st == 3);
      v[4] = (st == 4) || (st == 5);
      v[3] = (st == 6);
      v[2] = (st >= 1) && (st <= 6);
      v[1] = (st == 7);
      v[0] = (st == 8);
      return v;
   endfunction

   function automatic logic [7:0] obs_outs();
      return {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en,
              bus.busy, bus.halted, bus.error};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.run = 0; bus.halt_req = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.branch = 0; bus.uncond_branch = 0; bus.mem_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      mdl_count = 0;
   endtask

   // Number of cycles an instruction of this class/delay occupies
   function automatic int instr_len(input int kind, input int d);
      int n;
      n = 3;
      if (kind == 1 || kind == 2) n += 1 + d;
      if (kind == 0 || kind == 1) n += 1;
      return n;
   endfunction

   // Runs one instruction starting in FETCH. kind: 0 ALU, 1 LDUR, 2 STUR,
   // 3 CBZ, 4 B. d = mem_ready delay in cycles. halt_at = cycle index with
   // halt_req=1, or -1.
   task automatic run_instr(input int kind, input int d, input int halt_at,
                            input bit pend_in, output bit halted_after);
      int exp_q[$];
      int mem_idx;
      int st;
      exp_q = {1, 2, 3};
      if (kind == 1 || kind == 2) begin
         exp_q.push_back(4);
         for (int k = 0; k < d; k++) exp_q.push_back(5);
      end
      if (kind == 0 || kind == 1) exp_q.push_back(6);
      mem_idx = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         st = exp_q[i];
         bus.run      = 1'($urandom_range(0, 1));
         bus.halt_req = (i == halt_at);
         if (st == 2) begin
            bus.mem_read      = (kind == 1);
            bus.mem_write     = (kind == 2);
            bus.branch        = (kind == 3);
            bus.uncond_branch = (kind == 4);
         end else begin
            {bus.mem_read, bus.mem_write, bus.branch, bus.uncond_branch} =
               4'($urandom_range(0, 15));
         end
         if (st == 4 || st == 5) begin
            bus.mem_ready = (mem_idx == d);
            mem_idx++;
         end else begin
            bus.mem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         n_checks++;
         if (bus.state !== 4'(st)) begin
            n_bad++;
            $display("FAIL instr_state kind=%0d cyc=%0d: got %0d want %0d", kind, i, bus.state, st);
         end
         n_checks++;
         if (obs_outs() !== exp_outs(st)) begin
            n_bad++;
            $display("FAIL instr_outs kind=%0d cyc=%0d: got %b want %b", kind, i, obs_outs(), exp_outs(st));
         end
         n_checks++;
         if (bus.pc_update !== (i == exp_q.size() - 1)) begin
            n_bad++;
            $display("FAIL instr_pc_update kind=%0d cyc=%0d: got %b want %b", kind, i, bus.pc_update, (i == exp_q.size() - 1));
         end
         n_checks++;
         if (bus.instr_count !== CW'(mdl_count)) begin
            n_bad++;
            $display("FAIL instr_count kind=%0d cyc=%0d: got %0d want %0d", kind, i, bus.instr_count, mdl_count);
         end
         tick();
      end
      clear_inputs();
      mdl_count = (mdl_count + 1) % (1 << CW);
      halted_after = pend_in || (halt_at >= 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
      mdl_count = 0;
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
      n_checks++;
      if (obs_outs() !== 8'd0) begin n_bad++; $display("FAIL reset_outs: got %b want 0", obs_outs()); end
      n_checks++;
      if (bus.pc_update !== 1'b0) begin n_bad++; $display("FAIL reset_pc_update: got %b want 0", bus.pc_update); end
      n_checks++;
      if (bus.instr_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.instr_count); end
      // Idle with no run stays idle
      tick();
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd0) begin n_bad++; $display("FAIL idle_hold: got %0d want 0", bus.state); end
   endtask

   task automatic test_alu();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      run_instr(0, 0, -1, 1'b0, h);
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd1) begin n_bad++; $display("FAIL alu_next_fetch: got %0d want 1", bus.state); end
      n_checks++;
      if (bus.instr_count !== 4'd1) begin n_bad++; $display("FAIL alu_count: got %0d want 1", bus.instr_count); end
   endtask

   task automatic test_ldur_wait();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      run_instr(1, 3, -1, 1'b0, h);
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd1) begin n_bad++; $display("FAIL ldur_next_fetch: got %0d want 1", bus.state); end
   endtask

   task automatic test_stur_cbz();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      run_instr(2, 0, -1, 1'b0, h);
      run_instr(3, 0, -1, 1'b0, h);
      @(negedge clk);
      n_checks++;
      if (bus.instr_count !== 4'd2) begin n_bad++; $display("FAIL stur_cbz_count: got %0d want 2", bus.instr_count); end
   endtask

   task automatic test_halt();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      run_instr(0, 0, 1, 1'b0, h);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.state !== 4'd7 || obs_outs() !== exp_outs(7)) begin
            n_bad++;
            $display("FAIL halt_hold: got state %0d outs %b want state 7 outs %b", bus.state, obs_outs(), exp_outs(7));
         end
         n_checks++;
         if (bus.instr_count !== CW'(mdl_count)) begin n_bad++; $display("FAIL halt_count: got %0d want %0d", bus.instr_count, mdl_count); end
         tick();
      end
      // run together with halt_req: run wins, halt lands after one instruction
      bus.run = 1'b1;
      bus.halt_req = 1'b1;
      tick();
      run_instr(4, 0, 0, 1'b1, h);
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd7) begin n_bad++; $display("FAIL run_halt_same: got %0d want 7", bus.state); end
      // halt_req only in the final stage cycle of a CBZ
      bus.run = 1'b1;
      tick();
      run_instr(3, 0, 2, 1'b0, h);
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd7) begin n_bad++; $display("FAIL halt_last_cycle: got %0d want 7", bus.state); end
      n_checks++;
      if (bus.instr_count !== CW'(mdl_count)) begin n_bad++; $display("FAIL halt_last_count: got %0d want %0d", bus.instr_count, mdl_count); end
   endtask

   task automatic test_timeout();
      int tbl[7] = '{1, 2, 3, 4, 5, 5, 5};
      do_reset();
      bus.run = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         bus.run = 1'($urandom_range(0, 1));
         bus.mem_read = (tbl[i] == 2);
         bus.mem_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.state !== 4'(tbl[i]) || bus.pc_update !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_seq cyc=%0d: got state %0d pc %b want state %0d pc 0", i, bus.state, bus.pc_update, tbl[i]);
         end
         tick();
      end
      bus.run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus.state !== 4'd8 || obs_outs() !== exp_outs(8)) begin
            n_bad++;
            $display("FAIL timeout_error: got state %0d outs %b want state 8 outs %b", bus.state, obs_outs(), exp_outs(8));
         end
         n_checks++;
         if (bus.instr_count !== 4'd0 || bus.pc_update !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_no_retire: got count %0d pc %b want 0 0", bus.instr_count, bus.pc_update);
         end
         tick();
      end
      bus.run = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd0 || obs_outs() !== 8'd0) begin
         n_bad++;
         $display("FAIL timeout_reset: got state %0d outs %b want 0 0", bus.state, obs_outs());
      end
   endtask

   task automatic test_wrap();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) run_instr(0, 0, -1, 1'b0, h);
      @(negedge clk);
      n_checks++;
      if (bus.instr_count !== 4'd0) begin n_bad++; $display("FAIL wrap_count: got %0d want 0", bus.instr_count); end
   endtask

   task automatic test_reset_mid();
      bit h;
      do_reset();
      bus.run = 1'b1;
      tick();
      run_instr(0, 0, -1, 1'b0, h);
      run_instr(0, 0, -1, 1'b0, h);
      tick();                       // FETCH
      bus.branch = 1'b1;
      tick();                       // DECODE: CBZ
      bus.branch = 1'b0;
      reset = 1'b1;                 // EXECUTE, which would be the final cycle
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd3 || bus.pc_update !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_pc: got state %0d pc %b want state 3 pc 0", bus.state, bus.pc_update);
      end
      tick();
      reset = 1'b0;
      mdl_count = 0;
      @(negedge clk);
      n_checks++;
      if (bus.state !== 4'd0 || obs_outs() !== 8'd0 || bus.pc_update !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_outs: got state %0d outs %b pc %b want all 0", bus.state, obs_outs(), bus.pc_update);
      end
      n_checks++;
      if (bus.instr_count !== 4'd0) begin n_bad++; $display("FAIL reset_mid_count: got %0d want 0", bus.instr_count); end
   endtask

   task automatic test_random();
      bit h;
      int kind, d, halt_at;
      do_reset();
      bus.run = 1'b1;
      tick();
      for (int k = 0; k < 40; k++) begin
         kind = $urandom_range(0, 4);
         d = $urandom_range(0, 3);
         halt_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, instr_len(kind, d) - 1) : -1;
         run_instr(kind, d, halt_at, 1'b0, h);
         if (h) begin
            @(negedge clk);
            n_checks++;
            if (bus.state !== 4'd7) begin n_bad++; $display("FAIL rand_halted k=%0d: got %0d want 7", k, bus.state); end
            repeat ($urandom_range(0, 2)) tick();
            bus.run = 1'b1;
            tick();
         end
      end
      @(negedge clk);
      n_checks++;
      if (bus.instr_count !== CW'(mdl_count)) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", bus.instr_count, mdl_count); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_ldur_wait();
      test_stur_cbz();
      test_halt();
      test_timeout();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
